data_cache_assoc: RTL and testbench

Parametrised set-associative, write-back, write-allocate data cache that sits between the CPU datapath (ALU result as address, register operand as write data) and the block-wide data memory. It is the next generation of the team's direct-mapped `data_cache`. It adds the following over that block:
- configurable word width, block size, set count and associativity;
- LRU replacement;
- an explicit flush sequence;
- saturating hit/miss counters.

---
 rtl/data_cache_assoc.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_data_cache_assoc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_assoc.sv
// data_cache_assoc
// Set-associative, write-back, write-allocate data cache between the CPU
// datapath and a block-wide data memory. It uses LRU replacement, has an
// explicit flush sequence and keeps saturating hit/miss counters.
//
// Ports
//   clk, reset            : single clock; synchronous active-high reset
//   read, write           : CPU request (both high is treated as a write)
//   address, writedata    : CPU address {tag, index, offset} and store data
//   readdata, busywait    : CPU load data (combinational on a hit) and stall
//   flush, flush_done     : flush request (hold until accepted) and a
//                           one-cycle completion pulse
//   mem_read, mem_write   : block fetch / write-back requests
//   mem_address           : block address {tag, index}
//   mem_writedata         : victim block, word 0 in the LSBs
//   mem_readdata          : fetched block
//   mem_busywait          : memory stall
//   hit_count, miss_count : saturating request counters
module data_cache_assoc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int WORDS  = 4,
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            read,
    input  logic                            write,
    input  logic [ADDR_W-1:0]               address,
    input  logic [DATA_W-1:0]               writedata,
    output logic [DATA_W-1:0]               readdata,
    output logic                            busywait,
    input  logic                            flush,
    output logic                            flush_done,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0] mem_address,
    output logic [DATA_W*WORDS-1:0]         mem_writedata,
    input  logic [DATA_W*WORDS-1:0]         mem_readdata,
    input  logic                            mem_busywait,
    output logic [CNT_W-1:0]                hit_count,
    output logic [CNT_W-1:0]                miss_count
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W  = DATA_W * WORDS;
    localparam int AGES_W = WAYS * WAY_W;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WRITEBACK  = 3'd1;
    localparam logic [2:0] S_ALLOCATE   = 3'd2;
    localparam logic [2:0] S_UPDATE     = 3'd3;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
    localparam logic [2:0] S_FLUSH_WB   = 3'd5;

    // Reset ages: way w starts with age w, so way WAYS-1 is the first LRU victim.
    function automatic logic [AGES_W-1:0] init_ages();
        logic [AGES_W-1:0] ages;
        ages = '0;
        for (int w = 0; w < WAYS; w++) begin
            ages[w*WAY_W +: WAY_W] = WAY_W'(w);
        end
        return ages;
    endfunction

    localparam logic [AGES_W-1:0] AGES_RST = init_ages();

    // Touch a way: it becomes age 0 and every way younger than its old age ages by one.
    function automatic logic [AGES_W-1:0] lru_touch(input logic [AGES_W-1:0] ages,
                                                    input logic [WAY_W-1:0]  way);
        logic [AGES_W-1:0] next_ages;
        logic [WAY_W-1:0]  old_age;
        next_ages = ages;
        old_age   = ages[way*WAY_W +: WAY_W];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == way) begin
                next_ages[w*WAY_W +: WAY_W] = '0;
            end else if (ages[w*WAY_W +: WAY_W] < old_age) begin
                next_ages[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W] + WAY_W'(1);
            end else begin
                next_ages[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W];
            end
        end
        return next_ages;
    endfunction

    logic              valid_r [SETS][WAYS];
    logic              dirty_r [SETS][WAYS];
    logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
    logic [BLK_W-1:0]  data_r  [SETS][WAYS];
    logic [AGES_W-1:0] age_r   [SETS];

    logic [2:0]        state_r;
    logic [WAY_W-1:0]  victim_r;
    logic [BLK_W-1:0]  fill_r;
    logic              retry_r;
    logic [IDX_W-1:0]  scan_set_r;
    logic [WAY_W-1:0]  scan_way_r;
    logic              scan_end_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;

    logic [TAG_W-1:0]  tag_s;
    logic [IDX_W-1:0]  idx_s;
    logic [OFF_W-1:0]  off_s;
    logic              req_s;
    logic [WAYS-1:0]   hit_vec_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic [WAY_W-1:0]  old_way_s;
    logic [WAY_W-1:0]  victim_s;
    logic [DATA_W-1:0] hit_word_s;
    logic              last_line_s;

    assign tag_s       = address[ADDR_W-1 -: TAG_W];
    assign idx_s       = address[OFF_W +: IDX_W];
    assign off_s       = address[OFF_W-1:0];
    assign req_s       = read | write;
    assign hit_s       = |hit_vec_s;
    assign hit_word_s  = data_r[idx_s][hit_way_s][off_s*DATA_W +: DATA_W];
    assign last_line_s = (scan_set_r == IDX_W'(SETS-1)) && (scan_way_r == WAY_W'(WAYS-1));
    assign hit_count   = hit_cnt_r;
    assign miss_count  = miss_cnt_r;

    // Tag lookup and victim choice for the indexed set; at most one way can hit
    // and exactly one way holds the oldest age, so both encode by OR.
    always_comb begin
        hit_vec_s = '0;
        hit_way_s = '0;
        old_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s);
            hit_way_s    = hit_way_s | (hit_vec_s[w] ? WAY_W'(w) : '0);
            old_way_s    = old_way_s |
                ((age_r[idx_s][w*WAY_W +: WAY_W] == WAY_W'(WAYS-1)) ? WAY_W'(w) : '0);
        end
        victim_s = old_way_s;
        // Descending walk leaves the lowest-index invalid way, if any, as victim.
        for (int w = WAYS-1; w >= 0; w--) begin
            victim_s = valid_r[idx_s][w] ? victim_s : WAY_W'(w);
        end
    end

    // CPU and memory side outputs decoded from the state.
    always_comb begin
        readdata      = '0;
        busywait      = 1'b1;
        flush_done    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_r)
            S_IDLE: begin
                busywait = req_s & ~hit_s;
                readdata = (read & ~write & hit_s) ? hit_word_s : '0;
            end
            S_WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_r[idx_s][victim_r], idx_s};
                mem_writedata = data_r[idx_s][victim_r];
            end
            S_ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = address[ADDR_W-1:OFF_W];
            end
            S_FLUSH_SCAN: begin
                flush_done = scan_end_r;
            end
            S_FLUSH_WB: begin
                mem_write     = 1'b1;
                mem_address   = {tag_r[scan_set_r][scan_way_r], scan_set_r};
                mem_writedata = data_r[scan_set_r][scan_way_r];
            end
            default: begin
                busywait = 1'b1;
            end
        endcase
    end

    // Controller, line storage, LRU ages, flush scan pointer and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            victim_r   <= '0;
            fill_r     <= '0;
            retry_r    <= 1'b0;
            scan_set_r <= '0;
            scan_way_r <= '0;
            scan_end_r <= 1'b0;
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
            for (int s = 0; s < SETS; s++) begin
                age_r[s] <= AGES_RST;
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w] <= 1'b0;
                    dirty_r[s][w] <= 1'b0;
                end
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    retry_r <= 1'b0;
                    if (req_s && hit_s) begin
                        if (write) begin
                            data_r[idx_s][hit_way_s][off_s*DATA_W +: DATA_W] <= writedata;
                            dirty_r[idx_s][hit_way_s] <= 1'b1;
                        end
                        age_r[idx_s] <= lru_touch(age_r[idx_s], hit_way_s);
                        // The hit that follows a refill belongs to an already counted miss.
                        if (!retry_r && (hit_cnt_r != {CNT_W{1'b1}})) begin
                            hit_cnt_r <= hit_cnt_r + CNT_W'(1);
                        end
                    end else if (req_s) begin
                        if (miss_cnt_r != {CNT_W{1'b1}}) begin
                            miss_cnt_r <= miss_cnt_r + CNT_W'(1);
                        end
                        victim_r <= victim_s;
                        state_r  <= (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s])
                                    ? S_WRITEBACK : S_ALLOCATE;
                    end else if (flush) begin
                        state_r    <= S_FLUSH_SCAN;
                        scan_set_r <= '0;
                        scan_way_r <= '0;
                        scan_end_r <= 1'b0;
                    end
                end
                S_WRITEBACK: begin
                    if (!mem_busywait) begin
                        state_r <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (!mem_busywait) begin
                        fill_r  <= mem_readdata;
                        state_r <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    data_r[idx_s][victim_r]  <= fill_r;
                    tag_r[idx_s][victim_r]   <= tag_s;
                    valid_r[idx_s][victim_r] <= 1'b1;
                    dirty_r[idx_s][victim_r] <= 1'b0;
                    age_r[idx_s]             <= lru_touch(age_r[idx_s], victim_r);
                    retry_r                  <= 1'b1;
                    state_r                  <= S_IDLE;
                end
                S_FLUSH_SCAN: begin
                    if (scan_end_r) begin
                        scan_end_r <= 1'b0;
                        state_r    <= S_IDLE;
                    end else if (valid_r[scan_set_r][scan_way_r] && dirty_r[scan_set_r][scan_way_r]) begin
                        state_r <= S_FLUSH_WB;
                    end else if (last_line_s) begin
                        scan_end_r <= 1'b1;
                    end else if (scan_way_r == WAY_W'(WAYS-1)) begin
                        scan_way_r <= '0;
                        scan_set_r <= scan_set_r + IDX_W'(1);
                    end else begin
                        scan_way_r <= scan_way_r + WAY_W'(1);
                    end
                end
                S_FLUSH_WB: begin
                    if (!mem_busywait) begin
                        dirty_r[scan_set_r][scan_way_r] <= 1'b0;
                        state_r                         <= S_FLUSH_SCAN;
                        if (last_line_s) begin
                            scan_end_r <= 1'b1;
                        end else if (scan_way_r == WAY_W'(WAYS-1)) begin
                            scan_way_r <= '0;
                            scan_set_r <= scan_set_r + IDX_W'(1);
                        end else begin
                            scan_way_r <= scan_way_r + WAY_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache_assoc.sv
// Directed bench for data_cache_assoc (default geometry, CNT_W=4 so that
// counter saturation is reachable). A read-only memory model answers fetches
// with a fixed pattern after a two-cycle stall; expected memory transactions
// are queued when the stimulus is issued and popped as the cache completes them.
module tb_data_cache_assoc;
    localparam int CW = 4;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [7:0]  writedata = 8'h00;
    logic [7:0]  readdata;
    logic        busywait;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    logic        hold_busy = 1'b0;
    logic [7:0]  lat_cnt = 8'd0;
    txn_t        exp_q[$];
    int          total_checks = 0;
    int          pass_checks = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    data_cache_assoc #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busywait(busywait),
        .flush(flush), .flush_done(flush_done), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Memory contents: block 0 is 0x44332211, word i of block b is {b,i}^0x5A.
    function automatic logic [31:0] blk_val(input logic [5:0] b);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = {b, 2'(i)} ^ 8'h5A;
        if (b == 6'd0) v = 32'h44332211;
        return v;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 15) ? v + 1 : 15;
    endfunction

    assign mem_readdata = blk_val(mem_address);
    assign mem_busywait = (mem_read || mem_write) && (hold_busy || lat_cnt < 8'd2);

    // Memory stall counter: a request completes in its third cycle.
    always @(posedge clk) begin
        if (!(mem_read || mem_write)) lat_cnt <= 8'd0;
        else if (mem_busywait) lat_cnt <= lat_cnt + 8'd1;
        else lat_cnt <= 8'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) pass_checks++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_rd(input logic [5:0] a);
        exp_q.push_back({1'b0, a, 32'h0});
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    // Negedge sample point; scores any memory transaction completing this cycle.
    task automatic tick();
        txn_t t;
        @(negedge clk);
        if ((mem_read || mem_write) && !mem_busywait) begin
            chk("mem_txn_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                t = exp_q.pop_front();
                chk("mem_txn_write", 32'(mem_write), 32'(t.wr));
                chk("mem_txn_addr", 32'(mem_address), 32'(t.addr));
                if (t.wr) chk("mem_txn_wdata", mem_writedata, t.data);
            end
        end
    endtask

    task automatic apply_reset();
        read = 1'b0; write = 1'b0; flush = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hits = 0; exp_misses = 0;
        exp_q.delete();
    endtask

    task automatic cpu_access(input string tag, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic exp_hit, input logic [7:0] exp_rd);
        int n;
        read = !wr; write = wr; address = addr; writedata = wdata;
        tick();
        chk({tag, "_busy_first"}, 32'(busywait), 32'(!exp_hit));
        n = 0;
        while (busywait === 1'b1 && n < 60) begin
            @(posedge clk); #1;
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(busywait), 32'd0);
        if (!wr) chk({tag, "_rdata"}, 32'(readdata), 32'(exp_rd));
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        if (exp_hit) exp_hits = sat_inc(exp_hits);
        else exp_misses = sat_inc(exp_misses);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_hits"}, 32'(hit_count), 32'(exp_hits));
        chk({tag, "_misses"}, 32'(miss_count), 32'(exp_misses));
    endtask

    task automatic do_flush(input string tag, input int exp_n, input logic chk_n);
        int n;
        logic seen;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (flush_done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy"}, 32'(busywait), 32'd1);
        if (chk_n) chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
        @(posedge clk); #1;
        tick();
        chk({tag, "_pulse_end"}, 32'(flush_done), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        apply_reset();
        tick();
        chk("rst_readdata", 32'(readdata), 32'd0);
        chk("rst_busywait", 32'(busywait), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_wdata", mem_writedata, 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk_counts("rst");
        @(posedge clk); #1;

        // Cold read miss, then a hit in the same block
        push_rd(6'h00);
        cpu_access("cold_rd", 1'b0, 8'h00, 8'h00, 1'b0, 8'h11);
        chk_counts("cold_after_miss");
        cpu_access("cold_hit", 1'b0, 8'h01, 8'h00, 1'b1, 8'h22);
        chk_counts("cold_after_hit");
        chk("cold_q_drained", 32'(exp_q.size()), 32'd0);

        // LRU replacement and dirty eviction in set 0
        apply_reset();
        push_rd(6'h00);
        cpu_access("lru_fill0", 1'b0, 8'h00, 8'h00, 1'b0, 8'h11);
        push_rd(6'h08);
        cpu_access("lru_fill1", 1'b0, 8'h20, 8'h00, 1'b0, 8'h7A);
        cpu_access("lru_wr", 1'b1, 8'h00, 8'h55, 1'b1, 8'h00);
        push_rd(6'h10);
        cpu_access("lru_evict_clean", 1'b0, 8'h40, 8'h00, 1'b0, 8'h1A);
        v = blk_val(6'h00);
        v[7:0] = 8'h55;
        push_wr(6'h00, v);
        push_rd(6'h18);
        cpu_access("lru_evict_dirty", 1'b0, 8'h60, 8'h00, 1'b0, 8'h3A);
        chk_counts("lru");
        chk("lru_q_drained", 32'(exp_q.size()), 32'd0);

        // Write miss allocates, merges and leaves the line dirty
        apply_reset();
        push_rd(6'h01);
        cpu_access("wmiss", 1'b1, 8'h05, 8'h9A, 1'b0, 8'h00);
        cpu_access("wmiss_rd", 1'b0, 8'h05, 8'h00, 1'b1, 8'h9A);
        chk("wmiss_q_drained", 32'(exp_q.size()), 32'd0);
        push_rd(6'h03);
        cpu_access("wmiss2", 1'b1, 8'h0C, 8'h77, 1'b0, 8'h00);

        // Flush writes back exactly the two dirty lines, in scan order
        v = blk_val(6'h01);
        v[15:8] = 8'h9A;
        push_wr(6'h01, v);
        v = blk_val(6'h03);
        v[7:0] = 8'h77;
        push_wr(6'h03, v);
        do_flush("flush_dirty", 0, 1'b0);
        cpu_access("flush_keep_valid", 1'b0, 8'h05, 8'h00, 1'b1, 8'h9A);
        do_flush("flush_clean", 8 * 2 + 1, 1'b1);
        chk_counts("flush");

        // Reset while a fetch is stalled abandons it
        apply_reset();
        hold_busy = 1'b1;
        read = 1'b1; address = 8'h08;
        tick();
        chk("rstalloc_busy", 32'(busywait), 32'd1);
        @(posedge clk); #1;
        tick();
        chk("rstalloc_mem_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        tick();
        reset = 1'b1; read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; hold_busy = 1'b0;
        exp_hits = 0; exp_misses = 0;
        tick();
        chk("rstalloc_mem_read_after", 32'(mem_read), 32'd0);
        chk("rstalloc_busy_after", 32'(busywait), 32'd0);
        chk_counts("rstalloc");
        @(posedge clk); #1;
        push_rd(6'h02);
        cpu_access("rstalloc_reread", 1'b0, 8'h08, 8'h00, 1'b0, 8'h52);
        chk("rstalloc_q_drained", 32'(exp_q.size()), 32'd0);

        // Hit counter saturates
        apply_reset();
        push_rd(6'h04);
        cpu_access("sat_fill", 1'b0, 8'h10, 8'h00, 1'b0, 8'h4A);
        for (int i = 0; i < 20; i++) begin
            cpu_access("sat_hit", 1'b0, 8'h10 + 8'(i % 4), 8'h00, 1'b1, (8'h10 + 8'(i % 4)) ^ 8'h5A);
        end
        chk_counts("sat");
        chk("sat_hit_value", 32'(hit_count), 32'd15);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end
endmodule
